// File: rtl/ttt_board_ctrl.sv
// ---------------------------------------------------------------------------
// ttt_board_ctrl
//
// Purpose:
//   Game controller for the tic-tac-toe win-detection datapath. It accepts
//   player moves over a valid/ready handshake and rejects illegal moves. It
//   builds the ain/bin occupancy vectors that feed DetectWinner, and it reads
//   DetectWinner's win_line back one cycle after each placement to declare an
//   A win, a B win, or a draw.
//
// Parameters:
//   FIRST_PLAYER    - player who moves first after reset (0 = A, 1 = B)
//   ALTERNATE_START - when 1, the starting player flips on every new_game
//
// Optional build macro:
//   TTT_UNDO_EN     - adds the 'undo' input and a one-level last-move undo
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   move_valid in   move request
//   move_pos   in   [3:0] square index 0..8 (bit n of ain/bin)
//   move_ready out  controller can accept a move (PLAY state)
//   new_game   in   clear board and start a new game (highest priority)
//   undo       in   (TTT_UNDO_EN only) take back the last placed square
//   win_line   in   [7:0] from DetectWinner, combinational from ain/bin
//   ain        out  [8:0] player A occupancy
//   bin        out  [8:0] player B occupancy
//   turn       out  0 = A to move, 1 = B to move
//   game_over  out  terminal state reached
//   winner     out  [1:0] 00 none, 01 A, 10 B, 11 draw
//   illegal    out  one-cycle pulse on a rejected move
//   move_count out  [3:0] moves accepted this game, 0..9
// ---------------------------------------------------------------------------
module ttt_board_ctrl #(
    parameter logic FIRST_PLAYER    = 1'b0,
    parameter logic ALTERNATE_START = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       move_valid,
    input  logic [3:0] move_pos,
    output logic       move_ready,
    input  logic       new_game,
`ifdef TTT_UNDO_EN
    input  logic       undo,
`endif
    input  logic [7:0] win_line,
    output logic [8:0] ain,
    output logic [8:0] bin,
    output logic       turn,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       illegal,
    output logic [3:0] move_count
);

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [8:0] ain_d, bin_d;
    logic       turn_d;
    logic       game_over_d;
    logic [1:0] winner_d;
    logic       illegal_d;
    logic [3:0] move_count_d;
    logic       move_ready_d;
    logic       start_player, start_player_d;
    logic [8:0] sq_mask;
    logic       move_legal;
`ifdef TTT_UNDO_EN
    logic [3:0] last_pos, last_pos_d;
    logic       undo_avail, undo_avail_d;
    logic [8:0] last_mask;
`endif

    // One-hot mask of the requested square. Shifting by an index of 9..15
    // yields zero, but those indices are rejected by the range test anyway.
    // A move is legal only when it lands on the board and on an empty square.
    always_comb begin
        sq_mask    = 9'd1 << move_pos;
        move_legal = (move_pos <= 4'd8) && (((ain | bin) & sq_mask) == 9'd0);
    end

`ifdef TTT_UNDO_EN
    // Mask of the most recently placed square, cleared again on an undo.
    always_comb begin
        last_mask = 9'd1 << last_pos;
    end
`endif

    // Next-state and next-output logic. By default every register holds its
    // value and the illegal pulse is low. new_game overrides everything else,
    // including a move presented on the same edge. move_ready is computed
    // from the next state, so it is registered together with that state.
    always_comb begin
        state_d        = state_q;
        ain_d          = ain;
        bin_d          = bin;
        turn_d         = turn;
        game_over_d    = game_over;
        winner_d       = winner;
        illegal_d      = 1'b0;
        move_count_d   = move_count;
        start_player_d = start_player;
`ifdef TTT_UNDO_EN
        last_pos_d     = last_pos;
        undo_avail_d   = undo_avail;
`endif

        if (new_game) begin
            start_player_d = ALTERNATE_START ? ~start_player : FIRST_PLAYER;
            turn_d         = start_player_d;
            ain_d          = 9'd0;
            bin_d          = 9'd0;
            move_count_d   = 4'd0;
            winner_d       = 2'b00;
            game_over_d    = 1'b0;
            state_d        = PLAY;
`ifdef TTT_UNDO_EN
            undo_avail_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                PLAY: begin
                    if (move_valid) begin
                        if (move_legal) begin
                            if (turn) begin
                                bin_d = bin | sq_mask;
                            end else begin
                                ain_d = ain | sq_mask;
                            end
                            move_count_d = move_count + 4'd1;
                            state_d      = CHECK;
`ifdef TTT_UNDO_EN
                            last_pos_d   = move_pos;
                            undo_avail_d = 1'b1;
`endif
                        end else begin
                            illegal_d = 1'b1;
                        end
                    end
`ifdef TTT_UNDO_EN
                    else if (undo && undo_avail && (move_count != 4'd0)) begin
                        ain_d        = ain & ~last_mask;
                        bin_d        = bin & ~last_mask;
                        move_count_d = move_count - 4'd1;
                        turn_d       = ~turn;
                        undo_avail_d = 1'b0;
                    end
`endif
                end
                CHECK: begin
                    if (win_line != 8'd0) begin
                        winner_d    = turn ? 2'b10 : 2'b01;
                        game_over_d = 1'b1;
                        state_d     = DONE;
                    end else if (move_count == 4'd9) begin
                        winner_d    = 2'b11;
                        game_over_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        turn_d  = ~turn;
                        state_d = PLAY;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = PLAY;
                end
            endcase
        end

        move_ready_d = (state_d == PLAY);
    end

    // State and output registers. The asynchronous reset clears the board
    // immediately and discards any result still pending in CHECK.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= PLAY;
            ain          <= 9'd0;
            bin          <= 9'd0;
            turn         <= FIRST_PLAYER;
            game_over    <= 1'b0;
            winner       <= 2'b00;
            illegal      <= 1'b0;
            move_count   <= 4'd0;
            move_ready   <= 1'b1;
            start_player <= FIRST_PLAYER;
        end else begin
            state_q      <= state_d;
            ain          <= ain_d;
            bin          <= bin_d;
            turn         <= turn_d;
            game_over    <= game_over_d;
            winner       <= winner_d;
            illegal      <= illegal_d;
            move_count   <= move_count_d;
            move_ready   <= move_ready_d;
            start_player <= start_player_d;
        end
    end

`ifdef TTT_UNDO_EN
    // Undo bookkeeping: where the last stone went, and whether it may still
    // be taken back. Only one level of undo is kept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_pos   <= 4'd0;
            undo_avail <= 1'b0;
        end else begin
            last_pos   <= last_pos_d;
            undo_avail <= undo_avail_d;
        end
    end
`endif

endmodule
